// File: rtl/ram_sp_clear_pkg.sv
// ============================================================================
// Module  : ram_sp_clear_pkg
// Purpose : Shared definitions for the clearable single-clock RAM: sweep FSM
//           state encodings and default geometry.
// Ports   : none (package)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_sp_clear_pkg;

    // Default geometry: the original 16K x 16 data/screen memory.
    localparam int RAM_DATA_W_DEF = 16;
    localparam int RAM_DEPTH_DEF  = 16384;

    // Clear sweep sequencer states.
    typedef enum logic [0:0] {
        RAM_ST_CLEAR = 1'b0,
        RAM_ST_READY = 1'b1
    } ram_state_t;

endpackage : ram_sp_clear_pkg

`default_nettype wire

// File: rtl/ram_clear_seq.sv
// ============================================================================
// Module  : ram_clear_seq
// Purpose : CLEAR/READY sequencer that sweeps zeroes through every RAM word
//           after reset or on request, one word per clock.
// Ports   : clk       - rising-edge clock
//           rst_n     - asynchronous active-low reset (restarts the sweep)
//           clear_req - start a new sweep; sampled only in READY
//           busy      - high while reset is asserted or a sweep is running
//           clr_we    - sweep write strobe into the memory array
//           clr_addr  - word being zeroed this cycle
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_clear_seq
    import ram_sp_clear_pkg::*;
#(
    parameter int DEPTH  = RAM_DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

    ram_state_t        r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_busy;

    // The edge that writes the last word is also the edge that leaves CLEAR,
    // so a sweep occupies exactly DEPTH edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RAM_ST_CLEAR;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                RAM_ST_CLEAR: begin
                    if (r_clr_cnt == c_last) begin
                        r_state   <= RAM_ST_READY;
                        r_clr_cnt <= '0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
                    end
                end
                RAM_ST_READY: begin
                    if (clear_req) begin
                        r_state   <= RAM_ST_CLEAR;
                        r_clr_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= RAM_ST_CLEAR;
                    r_clr_cnt <= '0;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign clr_we   = (r_state == RAM_ST_CLEAR);
    assign clr_addr = r_clr_cnt;

endmodule : ram_clear_seq

`default_nettype wire

// File: rtl/ram_sp_clear.sv
// ============================================================================
// Module  : ram_sp_clear
// Purpose : Parametrised single-clock RAM with separate write and read ports,
//           registered 1-cycle read with valid flag, and a built-in clear
//           sweep that zeroes every word after reset or on request.
// Ports   : clk       - rising-edge clock
//           rst_n     - asynchronous active-low reset
//           clear_req - start a full-memory clear (accepted only when idle)
//           busy      - high during reset and while clearing
//           wr_en     - write strobe
//           wr_addr   - write address (out-of-range writes are dropped)
//           wr_data   - write data
//           rd_en     - read strobe
//           rd_addr   - read address (out-of-range reads return zero)
//           rd_data   - registered read data
//           rd_valid  - one-cycle pulse when rd_data was updated
// Config  : RAM_BYPASS_EN defined   -> write-first on same-address collision
//           RAM_BYPASS_EN undefined -> read-first (old word returned)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_sp_clear
    import ram_sp_clear_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W_DEF,
    parameter int DEPTH  = RAM_DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    // One extra bit so DEPTH itself is representable even for powers of two.
    localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_wr_ok;
    logic              w_rd_in_range;
    logic [DATA_W-1:0] w_rd_word;

    ram_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .busy      (w_busy),
        .clr_we    (w_clr_we),
        .clr_addr  (w_clr_addr)
    );

    assign w_wr_ok       = wr_en && !w_busy && ({1'b0, wr_addr} < c_depth);
    assign w_rd_in_range = ({1'b0, rd_addr} < c_depth);

    // Single write port: the sweep owns it while clearing, the user otherwise.
    // The array itself has no reset; only the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        w_rd_word = '0;
        if (w_rd_in_range) begin
            w_rd_word = r_mem[rd_addr];
`ifdef RAM_BYPASS_EN
            // Write-first: forward the word being written this same edge.
            if (w_wr_ok && (wr_addr == rd_addr)) begin
                w_rd_word = wr_data;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (rd_en && !w_busy) begin
            r_rd_data  <= w_rd_word;
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    assign busy     = w_busy;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

endmodule : ram_sp_clear

`default_nettype wire

// File: tb/tb_ram_sp_clear.sv
// ============================================================================
// Module  : tb_ram_sp_clear
// Purpose : Self-checking bench for ram_sp_clear: a DEPTH=16 instance for the
//           main function, a DEPTH=12 instance for address bounds and a
//           default-geometry instance for the full-size sweep length.
// Config  : honours RAM_BYPASS_EN for the same-address collision expectation
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_sp_clear;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] exp_q [$];
    logic [15:0] model_a [16];
    logic [15:0] model_b [12];

    // ---------------- instance A: DEPTH=16 ----------------
    logic        a_rst_n, a_clear_req, a_busy, a_wr_en, a_rd_en, a_rd_valid;
    logic [3:0]  a_wr_addr, a_rd_addr;
    logic [15:0] a_wr_data, a_rd_data;

    ram_sp_clear #(.DATA_W(16), .DEPTH(16)) u_dut_a (
        .clk(clk), .rst_n(a_rst_n), .clear_req(a_clear_req), .busy(a_busy),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid)
    );

    // ---------------- instance B: DEPTH=12 ----------------
    logic        b_rst_n, b_clear_req, b_busy, b_wr_en, b_rd_en, b_rd_valid;
    logic [3:0]  b_wr_addr, b_rd_addr;
    logic [15:0] b_wr_data, b_rd_data;

    ram_sp_clear #(.DATA_W(16), .DEPTH(12)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n), .clear_req(b_clear_req), .busy(b_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
    );

    // ---------------- instance C: default geometry ----------------
    logic        c_rst_n, c_clear_req, c_busy, c_wr_en, c_rd_en, c_rd_valid;
    logic [13:0] c_wr_addr, c_rd_addr;
    logic [15:0] c_wr_data, c_rd_data;

    ram_sp_clear u_dut_c (
        .clk(clk), .rst_n(c_rst_n), .clear_req(c_clear_req), .busy(c_busy),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_valid(c_rd_valid)
    );

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        logic [15:0] exp;
        a_rst_n = 1'b0;
        tick(); tick();
        vectors++;
        if (a_busy !== 1'b1 || a_rd_valid !== 1'b0 || a_rd_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b rd_valid=%b rd_data=%h, required 1/0/0000",
                     a_busy, a_rd_valid, a_rd_data);
        end
        a_rst_n = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (a_busy === 1'b1 && n < 40);
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL reset_sweep_len: busy for %0d edges, required 16", n);
        end
        for (int i = 0; i < 16; i++) model_a[i] = 16'h0000;
        // read every word back-to-back
        for (int i = 0; i < 16; i++) begin
            a_rd_en = 1'b1; a_rd_addr = 4'(i);
            exp_q.push_back(model_a[i]);
            tick();
            exp = exp_q.pop_front();
            vectors++;
            if (a_rd_valid !== 1'b1 || a_rd_data !== exp) begin
                miscompares++;
                $display("FAIL reset_read[%0d]: valid=%b data=%h, required 1/%h", i, a_rd_valid, a_rd_data, exp);
            end
        end
        a_rd_en = 1'b0;
        tick();
        vectors++;
        if (a_rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_valid: rd_valid=%b, required 0", a_rd_valid);
        end
    endtask

    task automatic test_write_read();
        logic [15:0] vals [6];
        logic [15:0] exp;
        vals = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h2468, 16'hACE0};
        for (int i = 0; i < 6; i++) begin
            a_wr_en = 1'b1; a_wr_addr = 4'(i); a_wr_data = vals[i];
            model_a[i] = vals[i];
            tick();
        end
        a_wr_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a_rd_en = 1'b1; a_rd_addr = 4'(i);
            exp_q.push_back(model_a[i]);
            tick();
            exp = exp_q.pop_front();
            vectors++;
            if (a_rd_valid !== 1'b1 || a_rd_data !== exp) begin
                miscompares++;
                $display("FAIL wr_rd[%0d]: valid=%b data=%h, required 1/%h", i, a_rd_valid, a_rd_data, exp);
            end
        end
        a_rd_en = 1'b0;
        tick();
    endtask

    task automatic test_collision();
        logic [15:0] exp;
        a_wr_en = 1'b1; a_wr_addr = 4'd3; a_wr_data = 16'hBEEF;
        a_rd_en = 1'b1; a_rd_addr = 4'd3;
`ifdef RAM_BYPASS_EN
        exp_q.push_back(16'hBEEF);
`else
        exp_q.push_back(model_a[3]);
`endif
        model_a[3] = 16'hBEEF;
        tick();
        exp = exp_q.pop_front();
        vectors++;
        if (a_rd_valid !== 1'b1 || a_rd_data !== exp) begin
            miscompares++;
            $display("FAIL collision: valid=%b data=%h, required 1/%h", a_rd_valid, a_rd_data, exp);
        end
        a_wr_en = 1'b0;
        exp_q.push_back(model_a[3]);
        tick();
        exp = exp_q.pop_front();
        vectors++;
        if (a_rd_valid !== 1'b1 || a_rd_data !== exp) begin
            miscompares++;
            $display("FAIL collision_next: valid=%b data=%h, required 1/%h", a_rd_valid, a_rd_data, exp);
        end
        a_rd_en = 1'b0;
        tick();
    endtask

    task automatic test_clear_req();
        int n;
        logic [15:0] exp;
        logic [15:0] held;
        // request cycle: read and write still serviced
        a_clear_req = 1'b1;
        a_wr_en = 1'b1; a_wr_addr = 4'd7; a_wr_data = 16'h5555;
        a_rd_en = 1'b1; a_rd_addr = 4'd1;
        exp_q.push_back(model_a[1]);
        tick();
        exp = exp_q.pop_front();
        held = exp;
        vectors++;
        if (a_busy !== 1'b1 || a_rd_valid !== 1'b1 || a_rd_data !== exp) begin
            miscompares++;
            $display("FAIL clear_req_cycle: busy=%b valid=%b data=%h, required 1/1/%h",
                     a_busy, a_rd_valid, a_rd_data, exp);
        end
        // during the sweep: everything ignored, clear_req included
        a_wr_addr = 4'd2; a_wr_data = 16'hFFFF; a_rd_addr = 4'd0;
        n = 0;
        do begin
            tick();
            n++;
            vectors++;
            if (a_rd_valid !== 1'b0 || a_rd_data !== held) begin
                miscompares++;
                $display("FAIL busy_read_gate: valid=%b data=%h, required 0/%h", a_rd_valid, a_rd_data, held);
            end
        end while (a_busy === 1'b1 && n < 40);
        a_clear_req = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0;
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL clear_len: busy for %0d edges, required 16", n);
        end
        for (int i = 0; i < 16; i++) model_a[i] = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            a_rd_en = 1'b1; a_rd_addr = 4'(i);
            exp_q.push_back(model_a[i]);
            tick();
            exp = exp_q.pop_front();
            vectors++;
            if (a_rd_valid !== 1'b1 || a_rd_data !== exp) begin
                miscompares++;
                $display("FAIL cleared_read[%0d]: valid=%b data=%h, required 1/%h", i, a_rd_valid, a_rd_data, exp);
            end
        end
        a_rd_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_clear();
        int n;
        logic [15:0] exp;
        a_wr_en = 1'b1; a_wr_addr = 4'd4; a_wr_data = 16'h1111;
        model_a[4] = 16'h1111;
        tick();
        a_wr_en = 1'b0;
        a_rd_en = 1'b1; a_rd_addr = 4'd4;
        tick();
        a_rd_en = 1'b0;
        vectors++;
        if (a_rd_data !== 16'h1111) begin
            miscompares++;
            $display("FAIL pre_reset_read: data=%h, required 1111", a_rd_data);
        end
        a_clear_req = 1'b1;
        tick();
        a_clear_req = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        a_rst_n = 1'b0;
        #1;
        vectors++;
        if (a_busy !== 1'b1 || a_rd_valid !== 1'b0 || a_rd_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL mid_clear_reset: busy=%b valid=%b data=%h, required 1/0/0000",
                     a_busy, a_rd_valid, a_rd_data);
        end
        tick(); tick();
        a_rst_n = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (a_busy === 1'b1 && n < 40);
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL restart_sweep_len: busy for %0d edges, required 16", n);
        end
        for (int i = 0; i < 16; i++) model_a[i] = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            a_rd_en = 1'b1; a_rd_addr = 4'(i);
            exp_q.push_back(model_a[i]);
            tick();
            exp = exp_q.pop_front();
            vectors++;
            if (a_rd_valid !== 1'b1 || a_rd_data !== exp) begin
                miscompares++;
                $display("FAIL restart_read[%0d]: valid=%b data=%h, required 1/%h", i, a_rd_valid, a_rd_data, exp);
            end
        end
        a_rd_en = 1'b0;
        tick();
    endtask

    task automatic test_bounds();
        int n;
        logic [15:0] exp;
        b_rst_n = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (b_busy === 1'b1 && n < 40);
        vectors++;
        if (n != 12) begin
            miscompares++;
            $display("FAIL d12_sweep_len: busy for %0d edges, required 12", n);
        end
        for (int i = 0; i < 12; i++) begin
            b_wr_en = 1'b1; b_wr_addr = 4'(i); b_wr_data = 16'hA000 + 16'(i);
            model_b[i] = 16'hA000 + 16'(i);
            tick();
        end
        // out-of-range writes must be dropped, top word must touch nothing else
        b_wr_addr = 4'd13; b_wr_data = 16'hDEAD; tick();
        b_wr_addr = 4'd12; b_wr_data = 16'hBEEF; tick();
        b_wr_addr = 4'd15; b_wr_data = 16'hFFFF; tick();
        b_wr_addr = 4'd11; b_wr_data = 16'hC0DE; model_b[11] = 16'hC0DE; tick();
        b_wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b_rd_en = 1'b1; b_rd_addr = 4'(i);
            exp_q.push_back((i < 12) ? model_b[i] : 16'h0000);
            tick();
            exp = exp_q.pop_front();
            vectors++;
            if (b_rd_valid !== 1'b1 || b_rd_data !== exp) begin
                miscompares++;
                $display("FAIL d12_read[%0d]: valid=%b data=%h, required 1/%h", i, b_rd_valid, b_rd_data, exp);
            end
        end
        b_rd_en = 1'b0;
        tick();
    endtask

    task automatic test_default_depth();
        int n;
        logic [15:0] exp;
        c_rst_n = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (c_busy === 1'b1 && n < 17000);
        vectors++;
        if (n != 16384) begin
            miscompares++;
            $display("FAIL default_sweep_len: busy for %0d edges, required 16384", n);
        end
        c_wr_en = 1'b1; c_wr_addr = 14'd16383; c_wr_data = 16'h7E57;
        tick();
        c_wr_en = 1'b0;
        c_rd_en = 1'b1; c_rd_addr = 14'd16383;
        exp_q.push_back(16'h7E57);
        tick();
        exp = exp_q.pop_front();
        vectors++;
        if (c_rd_valid !== 1'b1 || c_rd_data !== exp) begin
            miscompares++;
            $display("FAIL default_top_word: valid=%b data=%h, required 1/%h", c_rd_valid, c_rd_data, exp);
        end
        c_rd_addr = 14'd0;
        exp_q.push_back(16'h0000);
        tick();
        exp = exp_q.pop_front();
        vectors++;
        if (c_rd_valid !== 1'b1 || c_rd_data !== exp) begin
            miscompares++;
            $display("FAIL default_word0: valid=%b data=%h, required 1/%h", c_rd_valid, c_rd_data, exp);
        end
        c_rd_en = 1'b0;
        tick();
    endtask

    initial begin
        a_rst_n = 1'b0; a_clear_req = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0;
        a_wr_addr = '0; a_rd_addr = '0; a_wr_data = '0;
        b_rst_n = 1'b0; b_clear_req = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;
        b_wr_addr = '0; b_rd_addr = '0; b_wr_data = '0;
        c_rst_n = 1'b0; c_clear_req = 1'b0; c_wr_en = 1'b0; c_rd_en = 1'b0;
        c_wr_addr = '0; c_rd_addr = '0; c_wr_data = '0;
        tick();

        test_reset();
        test_write_read();
        test_collision();
        test_clear_req();
        test_reset_mid_clear();
        test_bounds();
        test_default_depth();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_ram_sp_clear

`default_nettype wire
